// File: rtl/shift_register_universal_framed.sv
// Universal shift register (hold / shift either way / parallel load / clear)
// with a bit counter that detects complete WIDTH-bit frames and publishes
// each one on a registered frame output with a one-cycle valid strobe.
module shift_register_universal_framed #(
  parameter int unsigned  WIDTH = 8,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       Mode,
  input  logic             Dir,
  input  logic             Serial_IN,
  input  logic [WIDTH-1:0] Parallel_IN,
  output logic [WIDTH-1:0] OUT,
  output logic             Serial_OUT,
  output logic [WIDTH-1:0] Frame_OUT,
  output logic             Frame_Valid,
  output logic [CNT_W-1:0] Bit_Count
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHIFT = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;
  localparam logic [1:0] MODE_CLEAR = 2'b11;

  // Count value of the shift that completes a frame; also bounds the counter
  // for non-power-of-two widths.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] out_next;
  logic [CNT_W-1:0] cnt_next;
  logic             frame_done;

  // Next register contents, bit count and frame-completion flag per mode.
  always_comb begin
    out_next   = OUT;
    cnt_next   = Bit_Count;
    frame_done = 1'b0;
    case (Mode)
      MODE_HOLD: begin
        out_next = OUT;
      end
      MODE_SHIFT: begin
        if (Dir) begin
          out_next = {Serial_IN, OUT[WIDTH-1:1]};
        end else begin
          out_next = {OUT[WIDTH-2:0], Serial_IN};
        end
        if (Bit_Count == LAST_BIT) begin
          cnt_next   = '0;
          frame_done = 1'b1;
        end else begin
          cnt_next = Bit_Count + CNT_W'(1);
        end
      end
      MODE_LOAD: begin
        out_next = Parallel_IN;
        cnt_next = '0;
      end
      MODE_CLEAR: begin
        out_next = '0;
        cnt_next = '0;
      end
      default: begin
        out_next = OUT;
      end
    endcase
  end

  // State update; a completed frame is captured on the same edge as the final shift.
  always_ff @(posedge CLK) begin
    if (RST) begin
      OUT         <= '0;
      Bit_Count   <= '0;
      Frame_OUT   <= '0;
      Frame_Valid <= 1'b0;
    end else begin
      OUT         <= out_next;
      Bit_Count   <= cnt_next;
      Frame_Valid <= frame_done;
      if (frame_done) begin
        Frame_OUT <= out_next;
      end
    end
  end

  // Bit that leaves on the next shift in the currently selected direction.
  assign Serial_OUT = Dir ? OUT[0] : OUT[WIDTH-1];

endmodule

// File: tb/tb_shift_register_universal_framed.sv
// Self-checking bench: a WIDTH=4 and a WIDTH=5 instance, driven from a vector
// table plus hand-written abort/gapped sequences; expectations are queued at
// drive time and compared after the following clock edge.
module tb_shift_register_universal_framed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       rst4, dir4, sin4, so4, fv4;
  logic [1:0] mode4;
  logic [3:0] pin4, out4, fr4;
  logic [1:0] cnt4;

  // WIDTH=5 instance
  logic       rst5, dir5, sin5, so5, fv5;
  logic [1:0] mode5;
  logic [4:0] pin5, out5, fr5;
  logic [2:0] cnt5;

  shift_register_universal_framed #(.WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst4), .Mode(mode4), .Dir(dir4), .Serial_IN(sin4),
    .Parallel_IN(pin4), .OUT(out4), .Serial_OUT(so4), .Frame_OUT(fr4),
    .Frame_Valid(fv4), .Bit_Count(cnt4)
  );

  shift_register_universal_framed #(.WIDTH(5)) dut5 (
    .CLK(clk), .RST(rst5), .Mode(mode5), .Dir(dir5), .Serial_IN(sin5),
    .Parallel_IN(pin5), .OUT(out5), .Serial_OUT(so5), .Frame_OUT(fr5),
    .Frame_Valid(fv5), .Bit_Count(cnt5)
  );

  typedef struct {
    bit         sel;   // 0: WIDTH=4 instance, 1: WIDTH=5 instance
    bit         rst;
    bit [1:0]   mode;
    bit         dir;
    bit         sin;
    bit [7:0]   pin;
    bit [7:0]   eo;
    bit [7:0]   ef;
    bit         ev;
    bit [2:0]   ec;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  vec_t cur;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(bit sel, bit rst, bit [1:0] mode, bit dir, bit sin,
                              bit [7:0] pin, bit [7:0] eo, bit [7:0] ef, bit ev,
                              bit [2:0] ec);
    vec_t v;
    v.sel = sel; v.rst = rst; v.mode = mode; v.dir = dir; v.sin = sin;
    v.pin = pin; v.eo = eo; v.ef = ef; v.ev = ev; v.ec = ec;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus to the selected instance; the other holds.
  task automatic drive(input vec_t v);
    @(negedge clk);
    rst4 = 1'b0; mode4 = 2'b00; dir4 = v.dir; sin4 = 1'b0; pin4 = '0;
    rst5 = 1'b0; mode5 = 2'b00; dir5 = v.dir; sin5 = 1'b0; pin5 = '0;
    if (v.sel == 1'b0) begin
      rst4 = v.rst; mode4 = v.mode; sin4 = v.sin; pin4 = v.pin[3:0];
    end else begin
      rst5 = v.rst; mode5 = v.mode; sin5 = v.sin; pin5 = v.pin[4:0];
    end
    sb.push_back(v);
  endtask

  // Compare the queued expectation just after the edge that consumed it.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      if (cur.sel == 1'b0) begin
        check("w4_out",   8'(out4), cur.eo);
        check("w4_frame", 8'(fr4),  cur.ef);
        check("w4_valid", 8'(fv4),  8'(cur.ev));
        check("w4_count", 8'(cnt4), 8'(cur.ec));
        check("w4_sout",  8'(so4),  8'(cur.dir ? cur.eo[0] : cur.eo[3]));
      end else begin
        check("w5_out",   8'(out5), cur.eo);
        check("w5_frame", 8'(fr5),  cur.ef);
        check("w5_valid", 8'(fv5),  8'(cur.ev));
        check("w5_count", 8'(cnt5), 8'(cur.ec));
        check("w5_sout",  8'(so5),  8'(cur.dir ? cur.eo[0] : cur.eo[4]));
      end
    end
  end

  localparam bit [1:0] H = 2'b00, S = 2'b01, L = 2'b10, C = 2'b11;

  initial begin
    rst4 = 1'b1; mode4 = H; dir4 = 1'b0; sin4 = 1'b0; pin4 = '0;
    rst5 = 1'b1; mode5 = H; dir5 = 1'b0; sin5 = 1'b0; pin5 = '0;

    // Reset and hold (W4), and reset of W5
    tbl.push_back(mk(0, 1, H, 0, 0, 8'h0, 8'b0000, 8'b0000, 0, 0));
    tbl.push_back(mk(0, 1, H, 0, 0, 8'h0, 8'b0000, 8'b0000, 0, 0));
    tbl.push_back(mk(0, 0, H, 0, 0, 8'h0, 8'b0000, 8'b0000, 0, 0));
    tbl.push_back(mk(0, 0, H, 0, 0, 8'h0, 8'b0000, 8'b0000, 0, 0));
    tbl.push_back(mk(0, 0, H, 0, 0, 8'h0, 8'b0000, 8'b0000, 0, 0));
    tbl.push_back(mk(1, 1, H, 0, 0, 8'h0, 8'b00000, 8'b00000, 0, 0));
    tbl.push_back(mk(1, 1, H, 0, 0, 8'h0, 8'b00000, 8'b00000, 0, 0));
    // Left shifts, two back-to-back frames
    tbl.push_back(mk(0, 0, S, 0, 1, 8'h0, 8'b0001, 8'b0000, 0, 1));
    tbl.push_back(mk(0, 0, S, 0, 0, 8'h0, 8'b0010, 8'b0000, 0, 2));
    tbl.push_back(mk(0, 0, S, 0, 1, 8'h0, 8'b0101, 8'b0000, 0, 3));
    tbl.push_back(mk(0, 0, S, 0, 1, 8'h0, 8'b1011, 8'b1011, 1, 0));
    tbl.push_back(mk(0, 0, S, 0, 0, 8'h0, 8'b0110, 8'b1011, 0, 1));
    tbl.push_back(mk(0, 0, S, 0, 0, 8'h0, 8'b1100, 8'b1011, 0, 2));
    tbl.push_back(mk(0, 0, S, 0, 1, 8'h0, 8'b1001, 8'b1011, 0, 3));
    tbl.push_back(mk(0, 0, S, 0, 1, 8'h0, 8'b0011, 8'b0011, 1, 0));
    // Clear keeps the frame, then right shifts
    tbl.push_back(mk(0, 0, C, 1, 0, 8'h0, 8'b0000, 8'b0011, 0, 0));
    tbl.push_back(mk(0, 0, S, 1, 1, 8'h0, 8'b1000, 8'b0011, 0, 1));
    tbl.push_back(mk(0, 0, S, 1, 0, 8'h0, 8'b0100, 8'b0011, 0, 2));
    tbl.push_back(mk(0, 0, S, 1, 1, 8'h0, 8'b1010, 8'b0011, 0, 3));
    tbl.push_back(mk(0, 0, S, 1, 1, 8'h0, 8'b1101, 8'b1101, 1, 0));
    tbl.push_back(mk(0, 0, H, 1, 0, 8'h0, 8'b1101, 8'b1101, 0, 0));
    // Parallel load and serialise: Serial_OUT 1,0,0,1
    tbl.push_back(mk(0, 0, L, 0, 0, 8'b1001, 8'b1001, 8'b1101, 0, 0));
    tbl.push_back(mk(0, 0, S, 0, 0, 8'h0, 8'b0010, 8'b1101, 0, 1));
    tbl.push_back(mk(0, 0, S, 0, 0, 8'h0, 8'b0100, 8'b1101, 0, 2));
    tbl.push_back(mk(0, 0, S, 0, 0, 8'h0, 8'b1000, 8'b1101, 0, 3));
    tbl.push_back(mk(0, 0, S, 0, 0, 8'h0, 8'b0000, 8'b0000, 1, 0));

    for (int i = 0; i < tbl.size(); i++) drive(tbl[i]);

    // Abort by load after 2 shifts: no strobe, count back to 0
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b0001, 8'b0000, 0, 1));
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b0011, 8'b0000, 0, 2));
    drive(mk(0, 0, L, 0, 0, 8'b0110, 8'b0110, 8'b0000, 0, 0));
    // Abort by reset after 3 shifts, then a full post-reset frame
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b1101, 8'b0000, 0, 1));
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b1011, 8'b0000, 0, 2));
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b0111, 8'b0000, 0, 3));
    drive(mk(0, 1, S, 0, 1, 8'h0, 8'b0000, 8'b0000, 0, 0));
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b0001, 8'b0000, 0, 1));
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b0011, 8'b0000, 0, 2));
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b0111, 8'b0000, 0, 3));
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b1111, 8'b1111, 1, 0));
    // Direction change mid-frame: count continues
    drive(mk(0, 0, S, 0, 0, 8'h0, 8'b1110, 8'b1111, 0, 1));
    drive(mk(0, 0, S, 1, 0, 8'h0, 8'b0111, 8'b1111, 0, 2));
    drive(mk(0, 0, S, 1, 0, 8'h0, 8'b0011, 8'b1111, 0, 3));
    drive(mk(0, 0, S, 0, 1, 8'h0, 8'b0111, 8'b0111, 1, 0));
    drive(mk(0, 0, H, 0, 0, 8'h0, 8'b0111, 8'b0111, 0, 0));

    // Gapped frame on WIDTH=5, then clear retaining the frame
    drive(mk(1, 0, S, 0, 1, 8'h0, 8'b00001, 8'b00000, 0, 1));
    drive(mk(1, 0, H, 0, 0, 8'h0, 8'b00001, 8'b00000, 0, 1));
    drive(mk(1, 0, S, 0, 0, 8'h0, 8'b00010, 8'b00000, 0, 2));
    drive(mk(1, 0, H, 0, 0, 8'h0, 8'b00010, 8'b00000, 0, 2));
    drive(mk(1, 0, H, 0, 0, 8'h0, 8'b00010, 8'b00000, 0, 2));
    drive(mk(1, 0, S, 0, 1, 8'h0, 8'b00101, 8'b00000, 0, 3));
    drive(mk(1, 0, H, 0, 0, 8'h0, 8'b00101, 8'b00000, 0, 3));
    drive(mk(1, 0, S, 0, 1, 8'h0, 8'b01011, 8'b00000, 0, 4));
    drive(mk(1, 0, H, 0, 0, 8'h0, 8'b01011, 8'b00000, 0, 4));
    drive(mk(1, 0, S, 0, 0, 8'h0, 8'b10110, 8'b10110, 1, 0));
    drive(mk(1, 0, H, 0, 0, 8'h0, 8'b10110, 8'b10110, 0, 0));
    drive(mk(1, 0, C, 0, 0, 8'h0, 8'b00000, 8'b10110, 0, 0));

    @(negedge clk);
    mode4 = H; mode5 = H; rst4 = 1'b0; rst5 = 1'b0;
    @(posedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_register_universal_framed.md
Name: shift_register_universal_framed

Overview:
Parametrised universal shift register, the successor to the fixed 4-bit SIPO. Supports serial-in/serial-out shifting in either direction, parallel load, hold and clear. Adds a bit counter that detects complete WIDTH-bit frames and presents each one on a registered frame output with a one-cycle valid strobe. Used as the serial-to-parallel and parallel-to-serial front end for serial links in the design.

Parameters:
WIDTH, 8, register and frame width in bits; legal range WIDTH >= 2.
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden.

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous reset, active-high
Mode  input  2  00 hold, 01 shift, 10 parallel load, 11 clear
Dir  input  1  0: shift toward MSB, serial enters bit 0; 1: shift toward LSB, serial enters bit WIDTH-1
Serial_IN  input  1  serial data bit, sampled when Mode=01
Parallel_IN  input  WIDTH  data captured when Mode=10
OUT  output  WIDTH  live shift register contents
Serial_OUT  output  1  bit that leaves on the next shift
Frame_OUT  output  WIDTH  last completed frame, registered
Frame_Valid  output  1  one-cycle strobe, Frame_OUT updated this cycle
Bit_Count  output  CNT_W  shifts accumulated in current frame

Behaviour:
- Reset (RST=1 at clock edge) has priority over Mode. It forces OUT=0, Frame_OUT=0, Frame_Valid=0 and Bit_Count=0. A reset asserted mid-frame discards the partial frame.
- Mode=00 (hold): OUT, Bit_Count and Frame_OUT are unchanged. Frame_Valid=0.
- Mode=01 (shift):
  - With Dir=0, the next OUT is {OUT[WIDTH-2:0], Serial_IN}.
  - With Dir=1, the next OUT is {Serial_IN, OUT[WIDTH-1:1]}.
  - Bit_Count increments.
  - When Bit_Count==WIDTH-1 at the edge, the shift completes a frame:
    - Frame_OUT captures the new OUT value, the same edge as OUT updates.
    - Frame_Valid=1 for exactly that following cycle.
    - Bit_Count wraps to 0.
- Mode=10 (load): OUT=Parallel_IN, Bit_Count=0, Frame_Valid=0, Frame_OUT unchanged. A load mid-frame aborts the frame with no strobe.
- Mode=11 (clear): OUT=0, Bit_Count=0, Frame_Valid=0, Frame_OUT unchanged.
- Serial_OUT is combinational from OUT: OUT[WIDTH-1] when Dir=0, OUT[0] when Dir=1.
- Frame_Valid is registered. It is 0 in every cycle not directly following a frame-completing shift.
  - Back-to-back frames with continuous shifting give a strobe every WIDTH cycles.
- Latency:
  - Serial_IN appears in OUT 1 cycle after the shift edge.
  - Frame_OUT/Frame_Valid update on the same edge as the final shift.
- Dir may change between shifts mid-frame. The count continues and no error is flagged.
- Hold cycles inside a frame do not advance Bit_Count. Frames may be gapped arbitrarily.
- Non-power-of-2 WIDTH: Bit_Count never exceeds WIDTH-1.

Test Plan:
- Reset and hold, WIDTH=4:
  - Stimulus: RST=1 for 2 cycles, then Mode=00 for 3 cycles.
  - Required: OUT=0000, Frame_OUT=0000, Frame_Valid=0 and Bit_Count=0 throughout.
- Left-shift frame, WIDTH=4:
  - Stimulus: Dir=0, Mode=01, Serial_IN 1,0,1,1, then 0,0,1,1 with no gap.
  - Required: OUT 0001, 0010, 0101, 1011.
  - Frame_Valid=1 in the cycle after the 4th shift with Frame_OUT=1011, then again after the 8th shift with Frame_OUT=0011.
- Right-shift frame, WIDTH=4:
  - Stimulus: Dir=1, Mode=01, Serial_IN 1,0,1,1.
  - Required: OUT 1000, 0100, 1010, 1101. Frame_OUT=1101 with one strobe.
- Parallel load and serialise, WIDTH=4:
  - Stimulus: Mode=10 with Parallel_IN=1001, then Dir=0 and 4 shifts with Serial_IN=0.
  - Required: Serial_OUT sequence 1,0,0,1. Frame_Valid pulses after the 4th shift with Frame_OUT=0000.
- Abort cases, WIDTH=4:
  - Stimulus: 2 shifts, then Mode=10. Separately, 3 shifts, then RST=1, then 4 shifts.
  - Required: no strobe from either aborted frame. Bit_Count returns to 0. Only the post-reset 4th shift produces Frame_Valid.
- Gapped frame, WIDTH=5:
  - Stimulus: 5 shifts interleaved with hold cycles, then a clear.
  - Required: Bit_Count frozen during holds. A single strobe after the 5th shift. Clear gives OUT=00000 with Frame_OUT retained.
